// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: MUL, MULHU, DIVU, REMU over WIDTH run cycles.
// Define MDU_DIV_EN to build the restoring divider; without it DIVU/REMU complete at once with 0.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   res_nx;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, a[WIDTH-1:1]};
    endfunction

    assign acc_nx = mul_step(acc, mcand);

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic [2*WIDTH-1:0] div_nx;

    // Restoring step: the W+1-bit difference carries the trial sign in its MSB.
    // With a zero divisor the subtract never goes negative, giving all-ones/dividend.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {r, q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        if (diff[WIDTH])
            return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
        return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    assign div_nx = div_step(rem, quo, dvsr);
`endif

    always_comb begin
        res_nx = '0;
        case (op_q)
            2'b00:   res_nx = acc_nx[WIDTH-1:0];
            2'b01:   res_nx = acc_nx[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
            2'b10:   res_nx = div_nx[WIDTH-1:0];
            2'b11:   res_nx = div_nx[2*WIDTH-1:WIDTH];
`endif
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
`ifdef MDU_DIV_EN
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (!op_q[1]) begin
                    acc <= acc_nx;
                end
`ifdef MDU_DIV_EN
                else begin
                    rem <= div_nx[2*WIDTH-1:WIDTH];
                    quo <= div_nx[WIDTH-1:0];
                end
`endif
                // Last bit is folded in on this edge, so the result comes from the next-state value.
                if (cnt == LAST) begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= res_nx;
                end
            end else if (start) begin
                op_q  <= op;
                cnt   <= '0;
                acc   <= {{WIDTH{1'b0}}, src_b};
                mcand <= src_a;
`ifdef MDU_DIV_EN
                rem   <= '0;
                quo   <= src_a;
                dvsr  <= src_b;
                state <= RUN;
                busy  <= 1'b1;
`else
                if (op[1]) begin
                    state  <= DONE;
                    done   <= 1'b1;
                    result <= '0;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
`endif
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, multi-cycle corner sequences, random ops vs model.
module tb_mdu_iter;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int          seen_done;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o);
        return (!DIV_EN && o[1]) ? 1 : W + 1;
    endfunction

    // Called at a negedge: presents a request for one cycle, then scrambles operands.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'(($urandom));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Waits for done (bounded), counting cycles from the start cycle; optionally pulses start mid-run.
    task automatic await_done(input string name, input logic [31:0] exp, input int lat,
                              input int pulse_at);
        int cycles;
        int busy_bad;
        cycles   = 1;
        busy_bad = 0;
        while (done !== 1'b1 && cycles < 80) begin
            if (busy !== (lat > 1)) busy_bad++;
            if (cycles == pulse_at) begin
                start = 1'b1;
                op    = 2'b01;
                src_a = 32'hFFFF_FFFF;
                src_b = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk({name, " latency"}, 64'(cycles), 64'(lat));
        chk({name, " result"}, 64'(result), 64'(exp));
        chk({name, " busy during run"}, 64'(busy_bad), 64'd0);
        chk({name, " busy with done"}, 64'(busy), 64'd0);
    endtask

    task automatic settle(input string name);
        @(negedge clk);
        chk({name, " done pulse width"}, 64'(done), 64'd0);
        chk({name, " idle busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd42, 33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vecs[3] = '{2'b10, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1};
        vecs[4] = '{2'b11, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 33 : 1};
        vecs[5] = '{2'b10, 32'h1234, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 33 : 1};
        vecs[6] = '{2'b11, 32'h1234, 32'd0, DIV_EN ? 32'h0000_1234 : 32'd0, DIV_EN ? 33 : 1};
        vecs[7] = '{2'b01, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 33};

        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            await_done($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, 0);
            settle($sformatf("vec%0d", i));
        end

        // Back-to-back: start held in the DONE cycle launches the next op.
        issue(2'b00, 32'd7, 32'd6);
        await_done("b2b first", 32'd42, 33, 0);
        issue(2'b01, 32'h0001_0000, 32'h0003_0000);
        chk("b2b busy after restart", 64'(busy), 64'd1);
        await_done("b2b second", 32'd3, 33, 0);
        settle("b2b");

        // A start pulse during RUN must not disturb the running op.
        issue(2'b00, 32'd9, 32'd11);
        await_done("ignore start", 32'd99, 33, 5);
        settle("ignore start");

        // Flush mid-run: no completion, result keeps the previous value.
        issue(2'b00, 32'd7, 32'd6);
        await_done("pre-flush", 32'd42, 33, 0);
        settle("pre-flush");
        issue(DIV_EN ? 2'b10 : 2'b00, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy after", 64'(busy), 64'd0);
        chk("flush done after", 64'(done), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("flush no completion", 64'(seen_done), 64'd0);
        chk("flush result kept", 64'(result), 64'd42);

        // Asynchronous reset mid-run clears outputs before the next clock edge.
        issue(2'b00, $urandom, $urandom);
        repeat (7) @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset done", 64'(done), 64'd0);
        chk("async reset result", 64'(result), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd5);
        await_done("post-reset mul", 32'd15, 33, 0);
        settle("post-reset");

        for (int i = 0; i < 20; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 200));
            issue(r_op, r_a, r_b);
            await_done($sformatf("rand%0d op%0d", i, r_op), model(r_op, r_a, r_b),
                       model_lat(r_op), 0);
            settle($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative unsigned multiply/divide unit in the EX stage of the pipelined CPU. It computes 32-bit MUL, MULHU, DIVU and REMU over multiple cycles using a start/busy/done handshake. Its `result` drives one data input of the EX-stage 4:1 result-select mux. The hazard logic holds the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the counter and the 2×WIDTH accumulator scale with it.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder).
- `src_a`  in  WIDTH  multiplicand / dividend.
- `src_b`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  synchronous abort from the pipeline flush logic.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH  registered result; holds until the next completion.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start && !flush`.
  - RUN→DONE when the counter reaches WIDTH-1.
  - DONE→RUN on `start && !flush`, otherwise DONE→IDLE.
  - Any state→IDLE on `flush`.
- Accept: latch `op`, `src_a` and `src_b`; clear the 5-bit counter. Operands may change after acceptance.
- `start` is ignored in RUN. `flush` wins over a simultaneous `start`.
- MUL/MULHU: radix-2 shift-add, one multiplier bit per RUN cycle, into a 2×WIDTH accumulator. MUL returns bits [WIDTH-1:0]; MULHU returns bits [2W-1:W]. All arithmetic is unsigned and there is no overflow flag.
- DIVU/REMU: restoring division, one quotient bit per RUN cycle. The partial remainder is WIDTH+1 bits so the trial subtract sign is visible.
- Divide by zero has no special-case path. The restoring algorithm naturally yields quotient all-ones and remainder `src_a`, and latency is unchanged.
- `result` is written only on the RUN→DONE edge. A flushed or reset operation never writes `result` (reset clears it).
- Reset (`rstn`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, accumulators=0. This applies mid-operation too; the operation is lost.

## Timing
- `start` accepted at edge T: `busy`=1 from T through the edge that enters DONE. That is WIDTH RUN cycles.
- `done`=1 for exactly the single cycle in DONE (edge T+WIDTH to T+WIDTH+1). `busy`=0 in that cycle. `result` is valid from the same edge.
- Total latency is WIDTH+1 cycles (33 at default) from the `start` cycle to the `done` cycle.
- Back-to-back: `start` held high in the DONE cycle begins the next operation, with `busy` high on the following cycle. The throughput is one result per WIDTH+1 cycles.
- `flush` at edge F: `busy`=0 and `done`=0 from F+1, and `result` is unchanged.
- `busy` and `done` are never high together.

## Configuration
- `MDU_DIV_EN` defined: the full divider datapath is built and DIVU/REMU behave as above.
- `MDU_DIV_EN` undefined:
  - Divider registers and subtractor are removed.
  - `op` 10/11 is accepted and goes IDLE→DONE in one cycle, skipping RUN, with `busy` never asserted. `done` pulses in the cycle after `start` with `result`=0.
  - MUL/MULHU are unaffected.

## Test plan
- MUL 7×6 started at T → `busy` high T+1..T+32, `done` at T+33, `result`=42. MULHU 0xFFFFFFFF×0xFFFFFFFF → `result`=0xFFFFFFFE.
- DIVU 100/7 → `result`=14; REMU 100/7 → `result`=2. Both have the `done` pulse 33 cycles after `start`.
- DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x00001234. Latency is unchanged.
- MUL 7×6 completes (`result`=42). Then start DIVU; pulse `start` again 5 cycles into RUN (ignored); assert `flush` at RUN cycle 10. Required: `busy`=0 the next cycle, no `done` pulse, `result` still 42.
- Drop `rstn` low mid-RUN → `busy`, `done` and `result` are 0 immediately (asynchronously). After release, a new MUL 3×5 gives 15.
- Build without `MDU_DIV_EN`: DIVU 100/7 → `done` one cycle after `start`, `result`=0, `busy` never high. MUL 7×6 is still 42 at 33 cycles.
